// File: rtl/usb_tx_packet_sequencer.sv
// usb_tx_packet_sequencer
// Builds a full USB 1.1 packet (SYNC, PID, payload, CRC16) one byte at a time
// for the bit-level serializer. Payload bytes are popped from the endpoint
// buffer and folded into the CRC as they pass through.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   tx_start, tx_packet       start request and packet type (1..5)
//   buffer_occupancy          buffer byte count (latched at start, then
//                             only watched for underflow)
//   tx_packet_data            buffer read data, valid with the pop strobe
//   get_tx_packet_data        pop strobe to the buffer
//   byte_out/valid/last       byte register toward the serializer
//   byte_ready                serializer accept
//   tx_busy, tx_done, tx_error status
//
// state  | meaning (byte currently held in the output register)
// IDLE   | nothing to send, waiting for tx_start
// SYNC   | SYNC byte presented; PID loads next
// PID    | data PID presented; first payload byte or CRC low loads next
// DATA   | payload byte presented; next payload byte or CRC low loads next
// CRC_LO | CRC low byte presented; CRC high byte loads next
// CRC_HI | CRC high byte (last) presented; done once accepted
// FINISH | handshake PID (last) presented; done once accepted
module usb_tx_packet_sequencer #(
  parameter int MAX_PKT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [2:0] tx_packet,
  input  logic [6:0] buffer_occupancy,
  input  logic [7:0] tx_packet_data,
  output logic       get_tx_packet_data,
  output logic [7:0] byte_out,
  output logic       byte_valid,
  input  logic       byte_ready,
  output logic       byte_last,
  output logic       tx_busy,
  output logic       tx_done,
  output logic       tx_error
);

  localparam logic [6:0] MAX_CNT = 7'(MAX_PKT);

  typedef enum logic [2:0] {IDLE, SYNC, PID, DATA, CRC_LO, CRC_HI, FINISH} state_t;

  state_t      state_q, state_d;
  logic [2:0]  type_q, type_d;
  logic [6:0]  count_q, count_d;
  logic [15:0] crc_q, crc_d;
  logic [7:0]  byte_q, byte_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic        pop_c;
  logic        free_c;

  // Reflected CRC-16 (0xA001), all eight bit-steps unrolled in one cycle.
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c ^ {8'h00, d};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'hA001) : (r >> 1);
    end
    return r;
  endfunction

  function automatic logic [7:0] pid_of(input logic [2:0] t);
    case (t)
      3'd1:    return 8'hC3;
      3'd2:    return 8'h4B;
      3'd3:    return 8'hD2;
      3'd4:    return 8'h5A;
      3'd5:    return 8'h1E;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic is_data(input logic [2:0] t);
    return (t == 3'd1) || (t == 3'd2);
  endfunction

  always_comb begin
    state_d = state_q;
    type_d  = type_q;
    count_d = count_q;
    crc_d   = crc_q;
    byte_d  = byte_q;
    valid_d = valid_q;
    last_d  = last_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    pop_c   = 1'b0;
    free_c  = !valid_q || byte_ready;

    // Accepted byte with nothing loaded behind it empties the register.
    if (valid_q && byte_ready) begin
      valid_d = 1'b0;
      last_d  = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (tx_start && (tx_packet >= 3'd1) && (tx_packet <= 3'd5)) begin
          type_d  = tx_packet;
          count_d = is_data(tx_packet) ?
                    ((buffer_occupancy > MAX_CNT) ? MAX_CNT : buffer_occupancy) : 7'd0;
          crc_d   = 16'hFFFF;
          busy_d  = 1'b1;
          byte_d  = 8'h80;
          valid_d = 1'b1;
          last_d  = 1'b0;
          state_d = SYNC;
        end
      end
      SYNC: begin
        if (free_c) begin
          byte_d  = pid_of(type_q);
          valid_d = 1'b1;
          if (is_data(type_q)) begin
            state_d = PID;
          end else begin
            last_d  = 1'b1;
            state_d = FINISH;
          end
        end
      end
      PID, DATA: begin
        if (free_c) begin
          if (count_q == 7'd0) begin
            byte_d  = ~crc_q[7:0];
            valid_d = 1'b1;
            state_d = CRC_LO;
          end else if (buffer_occupancy == 7'd0) begin
            // Underflow: abandon the packet without CRC or EOP.
            err_d   = 1'b1;
            valid_d = 1'b0;
            last_d  = 1'b0;
            busy_d  = 1'b0;
            state_d = IDLE;
          end else begin
            pop_c   = 1'b1;
            byte_d  = tx_packet_data;
            valid_d = 1'b1;
            crc_d   = crc16_byte(crc_q, tx_packet_data);
            count_d = count_q - 7'd1;
            state_d = DATA;
          end
        end
      end
      CRC_LO: begin
        if (free_c) begin
          byte_d  = ~crc_q[15:8];
          valid_d = 1'b1;
          last_d  = 1'b1;
          state_d = CRC_HI;
        end
      end
      CRC_HI, FINISH: begin
        if (free_c) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      type_q  <= 3'd0;
      count_q <= 7'd0;
      crc_q   <= 16'hFFFF;
      byte_q  <= 8'h00;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      type_q  <= type_d;
      count_q <= count_d;
      crc_q   <= crc_d;
      byte_q  <= byte_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // The pop is suppressed during reset so the buffer never loses a byte
  // to a packet that is being dropped.
  assign get_tx_packet_data = pop_c && !rst;
  assign byte_out           = byte_q;
  assign byte_valid         = valid_q;
  assign byte_last          = last_q;
  assign tx_busy            = busy_q;
  assign tx_done            = done_q;
  assign tx_error           = err_q;

endmodule
